bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one port of the 128x256 dual-port accelerator BRAM between NUM_REQ requesters, e.g. DMA, systolic-array feed and accumulator writeback.
- Round-robin arbitration over valid/ready request channels; drives the BRAM port signals (en, we, addr, wdata).
- Returns read data on a single tagged response channel.
- Response backpressure is handled by freezing the port: BRAM output data holds while en is low, so no skid buffer is needed.
- One instance per BRAM port.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 8, BRAM word address width.
- DATA_W, 128, BRAM word width.
- ID_W, derived localparam = max(1, clog2(NUM_REQ)), response tag width.

Ports:
- clock  in  1  rising-edge clock; BRAM port shares it.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data; same slicing as req_addr.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  ID_W  index of the requester that issued the read.
- rsp_data  out  DATA_W  read data, passed combinationally from bram_rdata.
- bram_en  out  1  BRAM port enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM address.
- bram_wdata  out  DATA_W  BRAM write data.
- bram_rdata  in  DATA_W  BRAM registered output, valid the cycle after an enabled read.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - pending=0, rsp_valid=0, rsp_id=0, rr_ptr=0.
  - All req_ready=0, bram_en=0.
  - Reset mid-read discards the in-flight response; no rsp_valid follows.
- Port free condition: port_free = !pending || rsp_ready.
  - When port_free is low, no request is granted and bram_en=0. BRAM dout therefore holds the pending word.
- Arbitration, evaluated combinationally each cycle when port_free:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; first set bit wins index g.
  - req_ready[g]=1; all other bits 0. req_ready is never high for a requester whose req_valid is low.
  - bram_en=1, bram_we=req_write[g], bram_addr and bram_wdata taken from slice g.
  - No valid request: bram_en=0, req_ready=0, rr_ptr unchanged.
- Grant update: on a grant, rr_ptr <= (g+1) mod NUM_REQ, so a continuously requesting agent waits at most NUM_REQ-1 grants.
- Pending register, updated each clock:
  - Read granted: pending<=1, rsp_id<=g.
  - Else if rsp_ready: pending<=0.
  - Otherwise hold.
- Response channel:
  - rsp_valid = pending; rsp_data = bram_rdata.
  - Read latency: grant in cycle T gives rsp_valid in T+1.
  - Back-to-back reads sustain one per cycle while rsp_ready=1.
- Writes:
  - Complete at grant; no response is generated.
  - A write grant with a pending read requires rsp_ready in the same cycle, because the BRAM updates dout on writes too (read-first).
- Ordering:
  - Port operations are strictly in grant order.
  - A read granted after a write to the same address returns the new data.
  - A read and a write granted in the same cycle cannot occur (single grant).
- Requester contract (assert in bench):
  - Once req_valid[i] is high it stays high, with stable write/addr/wdata, until req_ready[i].
- No internal storage of data; the only state is pending, rsp_id and rr_ptr.

Decomposition:
- Shared package bram_ctrl_pkg:
  - BRAM_ADDR_W=8, BRAM_DATA_W=128 constants.
  - Typedef bram_req_t {write, addr, wdata}.
  - Function clog2.
- Sub-module rr_arbiter (NUM_REQ; inputs req, ptr; outputs grant one-hot and grant_idx):
  - Purely combinational.
  - Reused by the accumulator-bank scheduler.

Test Plan:
- Reset/idle: reset_n=0 then 1, no requests -> bram_en=0, rsp_valid=0, all req_ready=0 for 10 cycles.
- Single read: requester 1 reads addr 0x05 preloaded with 0xA5..A5 -> bram_en=1 in T; rsp_valid=1, rsp_id=1, rsp_data=0xA5..A5 in T+1.
- Contention: both requesters issue 8 continuous reads, rsp_ready=1 -> grants alternate 0,1,0,1...; 16 responses in 16 consecutive cycles; ids alternate.
- Backpressure: rsp_ready=0 for 5 cycles after a read of 0x10 -> rsp_data stable, bram_en=0, req_ready=0 throughout; first grant in the cycle rsp_ready returns to 1.
- Write-then-read: requester 0 writes 0x1234 to addr 0xFF, requester 1 then reads 0xFF -> rsp_data=0x1234, rsp_id=1; the write yields no rsp_valid.
- Reset mid-operation: reset_n pulled low in the cycle after a read grant -> rsp_valid=0 immediately; after release, rr_ptr=0, so requester 0 wins the first contended grant.

Source files
------------

// File: rtl/bram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// bram_ctrl_pkg: shared BRAM geometry, request record and clog2 helper. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bram_ctrl_pkg;

    localparam int BRAM_ADDR_W = 8;
    localparam int BRAM_DATA_W = 128;

    typedef struct packed {
        logic                   write;
        logic [BRAM_ADDR_W-1:0] addr;
        logic [BRAM_DATA_W-1:0] wdata;
    } bram_req_t;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// bram_port_arbiter_if: requester channels, tagged response and BRAM port. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bram_port_arbiter_if
    import bram_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = BRAM_ADDR_W,
    parameter int DATA_W  = BRAM_DATA_W
);
    localparam int ID_W = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      bram_en;
    logic                      bram_we;
    logic [ADDR_W-1:0]         bram_addr;
    logic [DATA_W-1:0]         bram_wdata;
    logic [DATA_W-1:0]         bram_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, bram_rdata,
        output req_ready, rsp_valid, rsp_id, rsp_data,
               bram_en, bram_we, bram_addr, bram_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, bram_rdata,
        input  req_ready, rsp_valid, rsp_id, rsp_data,
               bram_en, bram_we, bram_addr, bram_wdata
    );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick starting at ptr_i. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  wire logic [NUM_REQ-1:0] req_i,
    input  wire logic [IDX_W-1:0]   ptr_i,
    output logic      [NUM_REQ-1:0] grant_o,
    output logic      [IDX_W-1:0]   grant_idx_o
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        w_idx       = '0;
        w_found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!w_found && req_i[w_idx]) begin
                w_found        = 1'b1;
                grant_o[w_idx] = 1'b1;
                grant_idx_o    = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bram_port_arbiter.sv
// ----------------------------------------------------------------------------
// bram_port_arbiter: round-robin sharing of one BRAM port, tagged read response. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bram_port_arbiter
    import bram_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = BRAM_ADDR_W,
    parameter int DATA_W  = BRAM_DATA_W
) (
    input wire logic            clock,
    input wire logic            reset_n,
    bram_port_arbiter_if.slave  bus
);

    localparam int ID_W = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1;

    logic              pending_q, pending_d;
    logic [ID_W-1:0]   rsp_id_q,  rsp_id_d;
    logic [ID_W-1:0]   rr_ptr_q,  rr_ptr_d;

    logic               w_port_free;
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;

    // A stalled response freezes the port so BRAM dout keeps the pending word.
    assign w_port_free = !pending_q || bus.rsp_ready;
    assign w_req       = (reset_n && w_port_free) ? bus.req_valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr_arbiter (
        .req_i       (w_req),
        .ptr_i       (rr_ptr_q),
        .grant_o     (w_grant),
        .grant_idx_o (w_idx)
    );

    assign w_any          = |w_grant;
    assign bus.req_ready  = w_grant;
    assign bus.bram_en    = w_any;
    assign bus.bram_we    = w_any && bus.req_write[w_idx];
    assign bus.bram_addr  = bus.req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
    assign bus.bram_wdata = bus.req_wdata[int'(w_idx)*DATA_W +: DATA_W];

    assign bus.rsp_valid  = pending_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = bus.bram_rdata;

    always_comb begin
        pending_d = pending_q;
        rsp_id_d  = rsp_id_q;
        rr_ptr_d  = rr_ptr_q;
        if (w_any) begin
            rr_ptr_d = (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
        end
        if (w_any && !bus.req_write[w_idx]) begin
            pending_d = 1'b1;
            rsp_id_d  = w_idx;
        end else if (bus.rsp_ready) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
            rsp_id_q  <= '0;
            rr_ptr_q  <= '0;
        end else begin
            pending_q <= pending_d;
            rsp_id_q  <= rsp_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bram_port_arbiter: directed checks of bram_port_arbiter against a BRAM model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bram_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 8;
    localparam int DW = 128;

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    bram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    bram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Read-first synchronous BRAM; dout only changes on enabled cycles.
    logic [DW-1:0] mem [256];
    always @(posedge clock) begin
        if (bus.bram_en) begin
            bus.bram_rdata <= mem[bus.bram_addr];
            if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_wdata;
        end
    end

    function automatic logic [DW-1:0] wd(input logic [7:0] a);
        logic [7:0] b;
        b = a ^ 8'hA0;
        return {16{b}};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]          = v;
        bus.req_write[i]          = w;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    // Requester contract: a waiting request stays valid and stable until accepted.
    logic [NR-1:0]    prev_wait;
    logic [NR-1:0]    prev_write;
    logic [NR*AW-1:0] prev_addr;
    logic [NR*DW-1:0] prev_wdata;
    initial prev_wait = '0;
    always @(posedge clock) begin
        if (!reset_n) begin
            prev_wait = '0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (prev_wait[i]) begin
                    assert (bus.req_valid[i] && bus.req_write[i] == prev_write[i] &&
                            bus.req_addr[i*AW +: AW] == prev_addr[i*AW +: AW] &&
                            bus.req_wdata[i*DW +: DW] == prev_wdata[i*DW +: DW])
                    else begin
                        failures++;
                        $error("FAIL contract requester=%0d observed_valid=%0b expected_valid=1", i, bus.req_valid[i]);
                    end
                end
            end
            prev_wait  = bus.req_valid & ~bus.req_ready;
            prev_write = bus.req_write;
            prev_addr  = bus.req_addr;
            prev_wdata = bus.req_wdata;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            cnt [NR];
        logic [AW-1:0] last_addr;
        int            g;

        checks   = 0;
        failures = 0;
        for (int a = 0; a < 256; a++) mem[a] = wd(a[7:0]);
        bus.bram_rdata = '0;
        bus.rsp_ready  = 1'b1;
        bus.req_valid  = '0;
        bus.req_write  = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        reset_n        = 1'b0;

        // Reset and idle
        tick(); tick();
        check("reset_bram_en", bus.bram_en, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_req_ready", bus.req_ready, 0);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_bram_en", bus.bram_en, 0);
            check("idle_rsp_valid", bus.rsp_valid, 0);
            check("idle_req_ready", bus.req_ready, 0);
        end

        // Single read by requester 1
        tick();
        set_req(1, 1'b1, 1'b0, 8'h05, '0);
        #1;
        check("single_bram_en", bus.bram_en, 1);
        check("single_bram_we", bus.bram_we, 0);
        check("single_bram_addr", bus.bram_addr, 8'h05);
        check("single_req_ready", bus.req_ready, 2'b10);
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0);
        #1;
        check("single_rsp_valid", bus.rsp_valid, 1);
        check("single_rsp_id", bus.rsp_id, 1);
        check("single_rsp_data", bus.rsp_data, {16{8'hA5}});

        // Contention: 8 reads each, grants must alternate starting at 0
        cnt[0] = 0; cnt[1] = 0;
        last_addr = '0;
        for (int k = 0; k <= 16; k++) begin
            tick();
            set_req(0, cnt[0] < 8, 1'b0, 8'h20 + 8'(cnt[0]), '0);
            set_req(1, cnt[1] < 8, 1'b0, 8'h40 + 8'(cnt[1]), '0);
            #1;
            if (k < 16) begin
                g = k % 2;
                check("cont_req_ready", bus.req_ready, 2'b01 << g);
            end else begin
                g = -1;
                check("cont_req_ready_end", bus.req_ready, 0);
            end
            if (k >= 1) begin
                check("cont_rsp_valid", bus.rsp_valid, 1);
                check("cont_rsp_id", bus.rsp_id, (k - 1) % 2);
                check("cont_rsp_data", bus.rsp_data, wd(last_addr));
            end
            if (g >= 0) begin
                last_addr = (g == 0 ? 8'h20 : 8'h40) + 8'(cnt[g]);
                cnt[g]++;
            end
        end

        // Backpressure after a read of 0x10
        tick();
        set_req(0, 1'b1, 1'b0, 8'h10, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        #1;
        check("bp_grant", bus.req_ready, 2'b01);
        tick();
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 8'h11, '0);
        set_req(1, 1'b1, 1'b0, 8'h12, '0);
        #1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_data", bus.rsp_data, wd(8'h10));
            check("bp_bram_en", bus.bram_en, 0);
            check("bp_req_ready", bus.req_ready, 0);
        end
        tick();
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_data", bus.rsp_data, wd(8'h10));
        check("bp_release_grant", bus.req_ready, 2'b10);
        check("bp_release_addr", bus.bram_addr, 8'h12);
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0);
        #1;
        check("bp_rsp1_id", bus.rsp_id, 1);
        check("bp_rsp1_data", bus.rsp_data, wd(8'h12));
        check("bp_grant0", bus.req_ready, 2'b01);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        check("bp_rsp0_id", bus.rsp_id, 0);
        check("bp_rsp0_data", bus.rsp_data, wd(8'h11));

        // Write then read of 0xFF
        tick();
        set_req(0, 1'b1, 1'b1, 8'hFF, 128'h1234);
        #1;
        check("wr_grant", bus.req_ready, 2'b01);
        check("wr_bram_we", bus.bram_we, 1);
        check("wr_bram_wdata", bus.bram_wdata, 128'h1234);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b1, 1'b0, 8'hFF, '0);
        #1;
        check("wr_no_rsp", bus.rsp_valid, 0);
        check("rd_grant", bus.req_ready, 2'b10);
        check("rd_bram_we", bus.bram_we, 0);
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0);
        #1;
        check("wr_rd_rsp_valid", bus.rsp_valid, 1);
        check("wr_rd_rsp_id", bus.rsp_id, 1);
        check("wr_rd_rsp_data", bus.rsp_data, 128'h1234);

        // Reset in the cycle after a read grant
        tick();
        set_req(0, 1'b1, 1'b0, 8'h30, '0);
        #1;
        check("rst_pre_grant", bus.req_ready, 2'b01);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        reset_n = 1'b0;
        #1;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_bram_en", bus.bram_en, 0);
        tick();
        reset_n = 1'b1;
        #1;
        check("rst_after_rsp_valid", bus.rsp_valid, 0);
        tick();
        set_req(0, 1'b1, 1'b0, 8'h31, '0);
        set_req(1, 1'b1, 1'b0, 8'h32, '0);
        #1;
        check("rst_first_grant", bus.req_ready, 2'b01);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        check("rst_rsp0_id", bus.rsp_id, 0);
        check("rst_rsp0_data", bus.rsp_data, wd(8'h31));
        check("rst_second_grant", bus.req_ready, 2'b10);
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0);
        #1;
        check("rst_rsp1_id", bus.rsp_id, 1);
        check("rst_rsp1_data", bus.rsp_data, wd(8'h32));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
